rdma_sq_arbiter: RTL

// - Shares the single network RDMA send queue (dreq_t, 256 b) between N_REGIONS user regions.
// - Round-robin arbitration; per-region outstanding-request credits, returned by network acks (ack_t, 32 b).
// - Sits on the user side of the RDMA register-slice array.
// - Output SQ is registered, so the slice array can be driven directly.

---
 rtl/lynxTypes.sv | 18 +
 rtl/rr_arbiter_core.sv | 34 +++
 rtl/rdma_sq_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/lynxTypes.sv
// Shared RDMA shell types: send-queue request and network ack formats, plus the
// field constants the user-side blocks decode.
package lynxTypes;

   localparam int unsigned RDMA_SQ_BITS   = 256;
   localparam int unsigned RDMA_ACK_BITS  = 32;
   localparam int unsigned N_REGIONS_BITS = 4;
   localparam int unsigned ACK_VFID_LSB   = 8;

   typedef logic [RDMA_SQ_BITS-1:0] dreq_t;

   typedef struct packed {
      logic [RDMA_ACK_BITS-N_REGIONS_BITS-ACK_VFID_LSB-1:0] rsrvd;
      logic [N_REGIONS_BITS-1:0]                           vfid;
      logic [ACK_VFID_LSB-1:0]                             opcode;
   } ack_t;

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin picker: first eligible requester at or above rr_ptr,
// wrapping modulo N.
module rr_arbiter_core #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] rr_ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any_grant
);

   int unsigned   j;
   logic [IW-1:0] jj;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      j         = 0;
      jj        = '0;
      for (int unsigned i = 0; i < N; i++) begin
         j  = (32'(rr_ptr) + i) % N;
         jj = IW'(j);
         if (!any_grant && eligible[jj]) begin
            any_grant = 1'b1;
            grant[jj] = 1'b1;
            grant_idx = jj;
         end
      end
   end

endmodule

// File: rtl/rdma_sq_arbiter.sv
// Round-robin sharing of the RDMA send queue between user regions, with per-region
// credits returned by acks. Optional grant counters under RDMA_SQ_ARB_STATS_EN.
module rdma_sq_arbiter
   import lynxTypes::*;
#(
   parameter int unsigned N_REGIONS       = 4,
   parameter int unsigned MAX_OUTSTANDING = 16
) (
   input  logic                             aclk,
   input  logic                             areset,
   input  logic [N_REGIONS-1:0]             s_sq_valid,
   output logic [N_REGIONS-1:0]             s_sq_ready,
   input  logic [N_REGIONS*RDMA_SQ_BITS-1:0] s_sq_data,
   output logic                             m_sq_valid,
   input  logic                             m_sq_ready,
   output logic [RDMA_SQ_BITS-1:0]          m_sq_data,
   input  logic                             s_ack_valid,
   output logic                             s_ack_ready,
   input  logic [RDMA_ACK_BITS-1:0]         s_ack_data,
   output logic                             credit_err
`ifdef RDMA_SQ_ARB_STATS_EN
  ,input  logic                             stat_clr,
   output logic [N_REGIONS*32-1:0]          stat_grants
`endif
);

   localparam int unsigned IW = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

   logic [N_REGIONS-1:0] eligible, grant, ack_for;
   logic [IW-1:0]        grant_idx, rr_ptr_q, rr_ptr_d;
   logic                 any_grant, slot_free, fire;
   logic [CW-1:0]        credit_q [N_REGIONS];
   logic [CW-1:0]        credit_d [N_REGIONS];
   logic                 credit_err_q, credit_err_d;
   logic                 m_valid_q;
   dreq_t                m_data_q;
   ack_t                 ack;
   logic                 unused_ack_bits;

   assign ack             = s_ack_data;
   assign unused_ack_bits = ^{ack.rsrvd, ack.opcode};
   assign s_ack_ready     = 1'b1;
   assign m_sq_valid      = m_valid_q;
   assign m_sq_data       = m_data_q;
   assign credit_err      = credit_err_q;

   always_comb begin
      eligible = '0;
      ack_for  = '0;
      for (int unsigned i = 0; i < N_REGIONS; i++) begin
         eligible[i] = s_sq_valid[i] && (credit_q[i] != '0);
         ack_for[i]  = s_ack_valid && (32'(ack.vfid) == i);
      end
   end

   rr_arbiter_core #(
      .N  (N_REGIONS),
      .IW (IW)
   ) u_core (
      .eligible  (eligible),
      .rr_ptr    (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   assign slot_free  = !m_valid_q || m_sq_ready;
   assign fire       = slot_free && any_grant && !areset;
   assign s_sq_ready = fire ? grant : '0;
   assign rr_ptr_d   = (32'(grant_idx) == N_REGIONS - 1) ? '0 : grant_idx + IW'(1);

   // A grant and an ack to the same region cancel; a full counter never wraps.
   always_comb begin
      credit_err_d = credit_err_q;
      for (int unsigned i = 0; i < N_REGIONS; i++) begin
         credit_d[i] = credit_q[i];
      end
      if (s_ack_valid && (32'(ack.vfid) >= N_REGIONS)) begin
         credit_err_d = 1'b1;
      end
      for (int unsigned i = 0; i < N_REGIONS; i++) begin
         if (ack_for[i] && !(fire && grant[i])) begin
            if (credit_q[i] == CW'(MAX_OUTSTANDING)) begin
               credit_err_d = 1'b1;
            end else begin
               credit_d[i] = credit_q[i] + CW'(1);
            end
         end else if (fire && grant[i] && !ack_for[i]) begin
            credit_d[i] = credit_q[i] - CW'(1);
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int unsigned i = 0; i < N_REGIONS; i++) begin
            credit_q[i] <= CW'(MAX_OUTSTANDING);
         end
         credit_err_q <= 1'b0;
         rr_ptr_q     <= '0;
      end else begin
         for (int unsigned i = 0; i < N_REGIONS; i++) begin
            credit_q[i] <= credit_d[i];
         end
         credit_err_q <= credit_err_d;
         if (fire) begin
            rr_ptr_q <= rr_ptr_d;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
      end else if (fire) begin
         m_valid_q <= 1'b1;
         m_data_q  <= s_sq_data[32'(grant_idx)*RDMA_SQ_BITS +: RDMA_SQ_BITS];
      end else if (m_sq_ready) begin
         m_valid_q <= 1'b0;
      end
   end

`ifdef RDMA_SQ_ARB_STATS_EN
   logic [31:0] grants_q [N_REGIONS];

   always_ff @(posedge aclk) begin
      for (int unsigned i = 0; i < N_REGIONS; i++) begin
         if (areset || stat_clr) begin
            grants_q[i] <= '0;
         end else if (fire && grant[i]) begin
            grants_q[i] <= grants_q[i] + 32'd1;
         end
      end
   end

   for (genvar gi = 0; gi < N_REGIONS; gi++) begin : g_stat
      assign stat_grants[gi*32 +: 32] = grants_q[gi];
   end
`endif

endmodule
